// File: rtl/retire_trace_sink.sv
// Retirement trace capture: buffers writeback records in a FIFO and serializes
// each one as an 11-byte frame (sync, pc, imm, reg/exception word) on a byte stream.
module retire_trace_sink #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_exception,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_imm,
    input  logic [4:0]               in_rs1n,
    input  logic [4:0]               in_rs2n,
    input  logic [4:0]               in_rdn,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              drop_count,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [79:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_drop;
    logic          r_halted;
    state_t        r_state;
    logic [79:0]   r_frame;
    logic [3:0]    r_idx;
    logic          r_out_valid;
    logic [7:0]    r_out_data;

    logic          w_capture, w_full, w_empty, w_push, w_drop, w_pop;
    logic [79:0]   w_rec, w_head, w_frame_nxt;
    state_t        w_state_nxt;
    logic [3:0]    w_idx_nxt;

    // Byte 0 is the sync marker; bytes 1..10 walk the packed record LSB first.
    function automatic logic [7:0] frame_byte(input logic [79:0] f, input logic [3:0] idx);
        logic [6:0] lsb;
        lsb = {idx - 4'd1, 3'b000};
        return (idx == 4'd0) ? 8'h5A : f[lsb +: 8];
    endfunction

    assign w_rec     = {in_exception, in_rdn, in_rs2n, in_rs1n, in_imm, in_pc};
    assign w_capture = !r_halted && (in_valid || in_exception);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = w_capture && !w_full;
    assign w_drop    = w_capture && w_full;
    assign w_head    = r_mem[r_rd_ptr];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_frame_nxt = w_head;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (r_idx < 4'd10) begin
                        w_idx_nxt = r_idx + 4'd1;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_frame_nxt = w_head;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: storage array carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rec;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drop      <= '0;
            r_halted    <= 1'b0;
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            if (w_capture && in_exception) r_halted <= 1'b1;
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= (w_state_nxt == S_SEND);
            r_out_data  <= (w_state_nxt == S_SEND) ? frame_byte(w_frame_nxt, w_idx_nxt) : 8'h00;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign fifo_level = r_count;
    assign drop_count = r_drop;
    assign halted     = r_halted;
endmodule

// File: tb/tb_retire_trace_sink.sv
// Bench for retire_trace_sink: directed tables and sequences plus random traffic,
// all compared against a record/byte-queue model of the trace sink.
module tb_retire_trace_sink;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        exc;
    } rec_t;

    typedef struct {
        logic       v;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_exception = 1'b0;
    logic [31:0] in_pc = '0, in_imm = '0;
    logic [4:0]  in_rs1n = '0, in_rs2n = '0, in_rdn = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;
    logic        halted;

    always #5 clk = ~clk;

    retire_trace_sink #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_exception(in_exception),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1n(in_rs1n), .in_rs2n(in_rs2n), .in_rdn(in_rdn),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .drop_count(drop_count), .halted(halted)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: queued records, the bytes of the frame still to go, and status.
    rec_t       m_q[$];
    logic [7:0] m_cur[$];
    logic       m_sending = 1'b0;
    logic       m_halted  = 1'b0;
    int         m_drops   = 0;

    logic [7:0] acc_q[$];
    logic       prev_ov = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_load(input rec_t r);
        logic [15:0] word;
        m_cur.delete();
        m_cur.push_back(8'h5A);
        for (int i = 0; i < 4; i++) m_cur.push_back(r.pc[8*i +: 8]);
        for (int i = 0; i < 4; i++) m_cur.push_back(r.imm[8*i +: 8]);
        word = {r.exc, r.rd, r.rs2, r.rs1};
        m_cur.push_back(word[7:0]);
        m_cur.push_back(word[15:8]);
        m_sending = 1'b1;
    endfunction

    function automatic void m_edge(input logic v, input logic e, input rec_t r,
                                   input logic rdy, input logic rst_val);
        logic cap, full;
        rec_t rr;
        if (!rst_val) begin
            m_q.delete();
            m_cur.delete();
            m_sending = 1'b0;
            m_halted  = 1'b0;
            m_drops   = 0;
            return;
        end
        cap  = !m_halted && (v || e);
        full = (m_q.size() == 8);
        if (!m_sending) begin
            if (m_q.size() > 0) m_load(m_q.pop_front());
        end else if (rdy) begin
            void'(m_cur.pop_front());
            if (m_cur.size() == 0) begin
                if (m_q.size() > 0) m_load(m_q.pop_front());
                else m_sending = 1'b0;
            end
        end
        if (cap) begin
            rr = r;
            rr.exc = e;
            if (full) begin
                if (m_drops < 16'hFFFF) m_drops++;
            end else begin
                m_q.push_back(rr);
            end
            if (e) m_halted = 1'b1;
        end
    endfunction

    // One clock: drive, advance model at the edge, compare at the falling edge.
    task automatic step(input logic v, input logic e, input rec_t r,
                        input logic rdy, input logic rst_val);
        if (out_valid && rdy && rst_val) acc_q.push_back(out_data);
        in_valid = v; in_exception = e;
        in_pc = r.pc; in_imm = r.imm;
        in_rs1n = r.rs1; in_rs2n = r.rs2; in_rdn = r.rd;
        out_ready = rdy; rst = rst_val;
        prev_ov = out_valid;
        prev_data = out_data;
        @(posedge clk);
        m_edge(v, e, r, rdy, rst_val);
        @(negedge clk);
        if (prev_ov && !rdy && rst_val) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
        end
        check("out_valid", 32'(out_valid), 32'(m_sending));
        if (m_sending) check("out_data", 32'(out_data), 32'(m_cur[0]));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc  = $urandom;
        r.imm = $urandom;
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        r.rd  = 5'($urandom);
        r.exc = 1'b0;
        return r;
    endfunction

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, rand_rec(), rdy, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, rand_rec(), 1'b0, 1'b0);
    endtask

    initial begin
        vec_t       tbl[13];
        logic [7:0] sr_bytes[11];
        rec_t       r1, rx;
        int         run, max_run, peak, d0;

        @(negedge clk);
        // Reset state
        do_reset();
        do_reset();
        check("reset_out_data", 32'(out_data), 32'h00);

        // Single record, table-driven
        sr_bytes = '{8'h5A, 8'h04, 8'h01, 8'h00, 8'h00, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'h62, 8'h14};
        r1 = '{pc: 32'h0000_0104, imm: 32'hFFFF_FFF0, rs1: 5'd2, rs2: 5'd3, rd: 5'd5, exc: 1'b0};
        tbl[0]  = '{v: 1'b1, rdy: 1'b1, ev: 1'b0, ed: 8'h00};
        for (int k = 1; k <= 11; k++) tbl[k] = '{v: 1'b0, rdy: 1'b1, ev: 1'b1, ed: sr_bytes[k-1]};
        tbl[12] = '{v: 1'b0, rdy: 1'b1, ev: 1'b0, ed: 8'h00};
        for (int k = 0; k < 13; k++) begin
            step(tbl[k].v, 1'b0, r1, tbl[k].rdy, 1'b1);
            check("tbl_valid", 32'(out_valid), 32'(tbl[k].ev));
            if (tbl[k].ev) check("tbl_data", 32'(out_data), 32'(tbl[k].ed));
        end

        // Back-to-back: three records, contiguous 33-byte burst
        run = 0; max_run = 0; peak = 0;
        for (int k = 0; k < 43; k++) begin
            if (k < 3) step(1'b1, 1'b0, rand_rec(), 1'b1, 1'b1);
            else idle(1'b1);
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        check("b2b_run", 32'(max_run), 32'd33);
        check("b2b_peak_level", 32'(peak), 32'd2);
        check("b2b_drops", 32'(drop_count), 32'd0);

        // Overflow: 10 records with the sink stalled, then drain
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, rand_rec(), 1'b0, 1'b1);
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_drops", 32'(drop_count), 32'd1);
        acc_q.delete();
        for (int k = 0; k < 130; k++) idle(1'b1);
        check("ovf_drained_bytes", 32'(acc_q.size()), 32'd99);
        check("ovf_idle", 32'(out_valid), 32'd0);

        // Exception held for 5 cycles: one frame, halted from the first edge
        d0 = int'(drop_count);
        acc_q.delete();
        rx = rand_rec();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, rx, 1'b1, 1'b1);
            if (k == 0) check("exc_halted_first_edge", 32'(halted), 32'd1);
        end
        for (int k = 0; k < 30; k++) idle(1'b1);
        check("exc_frame_bytes", 32'(acc_q.size()), 32'd11);
        if (acc_q.size() == 11) check("exc_bit", 32'(acc_q[10][7]), 32'd1);
        check("exc_drops", 32'(drop_count), 32'(d0));
        do_reset();

        // Backpressure: ready 1,0,0,1 repeating over a frame
        acc_q.delete();
        step(1'b1, 1'b0, r1, 1'b1, 1'b1);
        for (int k = 0; k < 60; k++) idle((k % 4 == 0) || (k % 4 == 3));
        check("bp_bytes", 32'(acc_q.size()), 32'd11);
        if (acc_q.size() == 11) begin
            for (int k = 0; k < 11; k++) check("bp_byte", 32'(acc_q[k]), 32'(sr_bytes[k]));
        end

        // Reset mid-frame with two records queued
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, rand_rec(), 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("mid_level_before", 32'(fifo_level), 32'd2);
        do_reset();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        step(1'b1, 1'b0, rand_rec(), 1'b1, 1'b1);
        idle(1'b1);
        check("mid_new_valid", 32'(out_valid), 32'd1);
        check("mid_new_sync", 32'(out_data), 32'h5A);
        for (int k = 0; k < 15; k++) idle(1'b1);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic rs;
            rs = !(($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 39) == 0));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0, rand_rec(),
                 $urandom_range(0, 3) != 0, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
